uart_tx_fifo_cfg: RTL

// Parametrised UART transmitter. Supports 5-9 data bits, none/odd/even parity and 1 or 2 stop bits.
// Has an input FIFO, so the host can queue words and frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo_cfg.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_cfg.sv
// rtl/uart_tx_fifo_cfg.sv - configurable UART transmitter with a first-word-fall-through input FIFO
// Frames go out back-to-back while the FIFO has words; tx_pin is registered one clock behind state.
module uart_tx_fifo_cfg #(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CYCLE < 1) begin : g_bad_param
      $fatal(1, "uart_tx_fifo_cfg: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop, fifo_empty, tick;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_n;
  logic [CW-1:0]        cycle_cnt, cycle_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n, pin_n;

  assign head          = mem[rd_ptr];
  assign fifo_empty    = (count == '0);
  assign tx_data_ready = (count != (AW+1)'(FIFO_DEPTH));
  assign push          = tx_data_valid & tx_data_ready;
  assign fifo_level    = count;
  assign tx_busy       = (state != S_IDLE) || !fifo_empty;
  assign tick          = (cycle_cnt == CW'(CYCLE - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tx_pin    <= 1'b1;
    end else begin
      state     <= state_n;
      cycle_cnt <= cycle_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_bit_n;
      tx_pin    <= pin_n;
    end
  end

  always_comb begin
    state_n     = state;
    cycle_cnt_n = cycle_cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    par_bit_n   = par_bit;
    pop         = 1'b0;
    pin_n       = 1'b1;

    if (state != S_IDLE) cycle_cnt_n = tick ? '0 : cycle_cnt + CW'(1);

    case (state)
      S_IDLE: begin
        pin_n = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_n     = S_START;
          cycle_cnt_n = '0;
          bit_cnt_n   = '0;
          shreg_n     = head;
          par_bit_n   = (PARITY == 1) ? ~^head : ^head;
        end
      end
      S_START: begin
        pin_n = 1'b0;
        if (tick) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end
      end
      S_DATA: begin
        pin_n = shreg[0];
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        pin_n = par_bit;
        if (tick) begin
          state_n   = S_STOP;
          bit_cnt_n = '0;
        end
      end
      S_STOP: begin
        pin_n = 1'b1;
        if (tick) begin
          if (bit_cnt != 4'(STOP_BITS - 1)) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit so frames stay contiguous.
            pop       = 1'b1;
            state_n   = S_START;
            bit_cnt_n = '0;
            shreg_n   = head;
            par_bit_n = (PARITY == 1) ? ~^head : ^head;
          end else begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
